rect_request_issuer: RTL

Front-end feeder and result collector for the rectangle-placement engine. Accepts tagged rectangle requests over a valid/ready handshake and buffers them in a small FIFO. Launches one request into the engine's width/height inputs per engine slot, where a slot is 4 clk_i cycles. Tracks each in-flight request through the engine's fixed pipeline latency, then returns the engine's (x, y, strike) result paired with the original tag.

---
 rtl/placement_pkg.sv | 30 +++
 rtl/rect_req_fifo.sv | 55 +++++
 rtl/rect_request_issuer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/placement_pkg.sv
// Shared widths, engine timing constants and request/tracker types for the
// rectangle-placement front end.
package placement_pkg;

  localparam int WIDTH_W     = 5;
  localparam int HEIGHT_W    = 5;
  localparam int IDX_W       = 8;
  localparam int STRIKE_W    = 4;
  localparam int TAG_W       = 4;

  localparam int SLOT_CYCLES = 4;
  localparam int RESULT_LAT  = 7;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [HEIGHT_W-1:0] height;
    logic [WIDTH_W-1:0]  width;
  } rect_req_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } track_t;

  // A rectangle with either side zero can never be placed by the engine.
  function automatic logic is_zero_size(input rect_req_t r);
    return (r.width == '0) || (r.height == '0);
  endfunction

endpackage

// File: rtl/rect_req_fifo.sv
// Request buffer: synchronous FIFO with async active-low reset and an
// occupancy count; a push while full or a pop while empty is ignored.
module rect_req_fifo
  import placement_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  rect_req_t        data_i,
  input  logic             pop_i,
  output rect_req_t        data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   level_o
);

  rect_req_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_level == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_level == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order statements are evaluated.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level alone
  // decide which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/rect_request_issuer.sv
// Feeds buffered rectangle requests into the placement engine one per slot
// and pairs each engine result with its request tag after the pipeline delay.
module rect_request_issuer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SLOT_CYCLES  = placement_pkg::SLOT_CYCLES,
  parameter int SAMPLE_PHASE = 0,
  parameter int RESULT_LAT   = placement_pkg::RESULT_LAT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [placement_pkg::WIDTH_W-1:0]  req_width_i,
  input  logic [placement_pkg::HEIGHT_W-1:0] req_height_i,
  input  logic [placement_pkg::TAG_W-1:0]    req_tag_i,
  output logic [placement_pkg::WIDTH_W-1:0]  eng_width_o,
  output logic [placement_pkg::HEIGHT_W-1:0] eng_height_o,
  input  logic [placement_pkg::IDX_W-1:0]    eng_index_x_i,
  input  logic [placement_pkg::IDX_W-1:0]    eng_index_y_i,
  input  logic [placement_pkg::STRIKE_W-1:0] eng_strike_i,
  output logic                              rsp_valid_o,
  output logic [placement_pkg::TAG_W-1:0]    rsp_tag_o,
  output logic [placement_pkg::IDX_W-1:0]    rsp_x_o,
  output logic [placement_pkg::IDX_W-1:0]    rsp_y_o,
  output logic [placement_pkg::STRIKE_W-1:0] rsp_strike_o,
  output logic                              rsp_new_strike_o,
  output logic                              drop_o,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o
);

  import placement_pkg::*;

  localparam int PH_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int TRK_LEN = SLOT_CYCLES + RESULT_LAT;

  rect_req_t             w_req;
  rect_req_t             w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_xfer;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_launch;
  track_t                w_track_in;

  logic [PH_W-1:0]       r_phase;
  track_t [TRK_LEN-1:0]  r_track;
  logic [WIDTH_W-1:0]    r_eng_w;
  logic [HEIGHT_W-1:0]   r_eng_h;
  logic                  r_drop;
  logic                  r_rsp_valid;
  logic [TAG_W-1:0]      r_rsp_tag;
  logic [IDX_W-1:0]      r_rsp_x;
  logic [IDX_W-1:0]      r_rsp_y;
  logic [STRIKE_W-1:0]   r_rsp_strike;
  logic                  r_rsp_new_strike;

  assign w_req       = '{tag: req_tag_i, height: req_height_i, width: req_width_i};
  assign req_ready_o = !w_full;
  assign w_xfer      = req_valid_i && req_ready_o;
  assign w_push      = w_xfer && !is_zero_size(w_req);
  assign w_launch    = (r_phase == PH_W'(SAMPLE_PHASE));
  assign w_pop       = w_launch && !w_empty;

  rect_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_req),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (fifo_level_o)
  );

  // NOTE: defaulting every always_comb output first keeps the block free of
  // inferred latches whichever branch is taken.
  always_comb begin
    w_track_in = '0;
    if (w_launch) begin
      w_track_in.valid = !w_empty;
      w_track_in.tag   = w_empty ? '0 : w_head.tag;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_phase <= '0;
    end else if (r_phase == PH_W'(SLOT_CYCLES - 1)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_track          <= '0;
      r_eng_w          <= '0;
      r_eng_h          <= '0;
      r_drop           <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_tag        <= '0;
      r_rsp_x          <= '0;
      r_rsp_y          <= '0;
      r_rsp_strike     <= '0;
      r_rsp_new_strike <= 1'b0;
    end else begin
      r_track <= {r_track[TRK_LEN-2:0], w_track_in};
      // An empty FIFO launches 0/0, which the engine treats as a bubble.
      if (w_launch) begin
        r_eng_w <= w_empty ? '0 : w_head.width;
        r_eng_h <= w_empty ? '0 : w_head.height;
      end
      r_drop           <= w_xfer && is_zero_size(w_req);
      r_rsp_valid      <= r_track[TRK_LEN-1].valid;
      r_rsp_new_strike <= 1'b0;
      // rsp_strike doubles as the last captured strike, so it moves only here.
      if (r_track[TRK_LEN-1].valid) begin
        r_rsp_tag        <= r_track[TRK_LEN-1].tag;
        r_rsp_x          <= eng_index_x_i;
        r_rsp_y          <= eng_index_y_i;
        r_rsp_strike     <= eng_strike_i;
        r_rsp_new_strike <= (eng_strike_i != r_rsp_strike);
      end
    end
  end

  assign eng_width_o      = r_eng_w;
  assign eng_height_o     = r_eng_h;
  assign drop_o           = r_drop;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_tag_o        = r_rsp_tag;
  assign rsp_x_o          = r_rsp_x;
  assign rsp_y_o          = r_rsp_y;
  assign rsp_strike_o     = r_rsp_strike;
  assign rsp_new_strike_o = r_rsp_new_strike;

endmodule
